// File: rtl/mesi_isc_pkg.sv
// Shared encodings, widths and scheduler state type for the MESI ISC snoop scheduler.
package mesi_isc_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned MBUS_CMD_WIDTH = 3;
  localparam int unsigned CBUS_CMD_WIDTH = 3;

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP = 3'd0;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR  = 3'd1;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD  = 3'd2;

  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = 3'd0;
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = 3'd1;
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = 3'd2;
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = 3'd3;
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = 3'd4;

  typedef enum logic [1:0] {IDLE, SNOOP, ENABLE, ACK} sched_state_e;

endpackage

// File: rtl/mesi_isc_rr_arbiter.sv
// Combinational 4-way round-robin pick; the search starts just after the last winner.
module mesi_isc_rr_arbiter (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic       valid_o,
  output logic [1:0] win_o
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the closest requester overwrites the rest.
  always_comb begin
    valid_o = 1'b0;
    win_o   = last_i;
    idx     = last_i;
    for (int k = 4; k >= 1; k--) begin
      idx = last_i + 2'(k);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_snoop_sched.sv
// Main-bus arbiter and coherence-snoop sequencer for the 4-CPU MESI ISC.
// Optional wait-limit abort is built when MESI_ISC_SCHED_TIMEOUT_EN is defined.
module mesi_isc_snoop_sched #(
  parameter int unsigned ADDR_WIDTH     = mesi_isc_pkg::ADDR_WIDTH,
  parameter int unsigned MBUS_CMD_WIDTH = mesi_isc_pkg::MBUS_CMD_WIDTH,
  parameter int unsigned CBUS_CMD_WIDTH = mesi_isc_pkg::CBUS_CMD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [3:0][MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
  input  logic [3:0][ADDR_WIDTH-1:0]     mbus_addr_array_i,
  input  logic [3:0]                     cbus_ack_i,
  output logic [ADDR_WIDTH-1:0]          cbus_addr_o,
  output logic [3:0][CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  output logic [3:0]                     mbus_ack_o,
  output logic                           busy_o,
  output logic [1:0]                     grant_id_o,
  output logic                           sched_timeout_o
);
  import mesi_isc_pkg::*;

  localparam logic [MBUS_CMD_WIDTH-1:0] MWr = MBUS_CMD_WIDTH'(MBUS_WR);
  localparam logic [MBUS_CMD_WIDTH-1:0] MRd = MBUS_CMD_WIDTH'(MBUS_RD);
  localparam logic [CBUS_CMD_WIDTH-1:0] CNop = CBUS_CMD_WIDTH'(CBUS_NOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CWrSnoop = CBUS_CMD_WIDTH'(CBUS_WR_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CRdSnoop = CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CEnWr = CBUS_CMD_WIDTH'(CBUS_EN_WR);
  localparam logic [CBUS_CMD_WIDTH-1:0] CEnRd = CBUS_CMD_WIDTH'(CBUS_EN_RD);

  sched_state_e                     state_q;
  logic [1:0]                       grant_id_q;
  logic                             is_wr_q;
  logic [3:0]                       done_q;
  logic [ADDR_WIDTH-1:0]            cbus_addr_q;
  logic [3:0][CBUS_CMD_WIDTH-1:0]   cbus_cmd_q;
  logic [3:0]                       mbus_ack_q;
  logic                             busy_q;
  logic                             tmo_q;

  logic [3:0] req;
  logic       arb_valid;
  logic [1:0] arb_win;
  logic [3:0] self_mask, snoop_acc, done_nxt;
  logic       snoop_all, en_ack, accepted, timeout_hit;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req[i] = (mbus_cmd_array_i[i] == MWr) || (mbus_cmd_array_i[i] == MRd);
    end
  end

  mesi_isc_rr_arbiter u_arb (
    .req_i   (req),
    .last_i  (grant_id_q),
    .valid_o (arb_valid),
    .win_o   (arb_win)
  );

  // Acks count only from CPUs still being snooped; the requester never snoops itself.
  assign self_mask = 4'b0001 << grant_id_q;
  assign snoop_acc = cbus_ack_i & ~done_q & ~self_mask;
  assign done_nxt  = done_q | snoop_acc;
  assign snoop_all = &(done_nxt | self_mask);
  assign en_ack    = |(cbus_ack_i & self_mask);
  assign accepted  = ((state_q == SNOOP) && (snoop_acc != 4'b0000)) ||
                     ((state_q == ENABLE) && en_ack);

`ifdef MESI_ISC_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;

  assign timeout_hit = ((state_q == SNOOP) || (state_q == ENABLE)) && !accepted &&
                       (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == IDLE) || (state_q == ACK) || accepted) begin
      wait_cnt_q <= '0;
    end else if (!timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + CntW'(1);
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_id_q  <= 2'd3;
      is_wr_q     <= 1'b0;
      done_q      <= '0;
      cbus_addr_q <= '0;
      cbus_cmd_q  <= {4{CNop}};
      mbus_ack_q  <= '0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      mbus_ack_q <= '0;
      tmo_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_id_q  <= arb_win;
            is_wr_q     <= (mbus_cmd_array_i[arb_win] == MWr);
            cbus_addr_q <= mbus_addr_array_i[arb_win];
            busy_q      <= 1'b1;
            state_q     <= SNOOP;
            for (int j = 0; j < 4; j++) begin
              if (2'(j) == arb_win) begin
                cbus_cmd_q[j] <= CNop;
              end else begin
                cbus_cmd_q[j] <= (mbus_cmd_array_i[arb_win] == MWr) ? CWrSnoop : CRdSnoop;
              end
            end
          end
        end
        SNOOP, ENABLE: begin
          if (timeout_hit) begin
            tmo_q      <= 1'b1;
            cbus_cmd_q <= {4{CNop}};
            done_q     <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (state_q == SNOOP) begin
            done_q <= done_nxt;
            for (int j = 0; j < 4; j++) begin
              if (snoop_acc[j]) cbus_cmd_q[j] <= CNop;
            end
            if (snoop_all) begin
              cbus_cmd_q[grant_id_q] <= is_wr_q ? CEnWr : CEnRd;
              state_q                <= ENABLE;
            end
          end else if (en_ack) begin
            cbus_cmd_q <= {4{CNop}};
            mbus_ack_q <= self_mask;
            state_q    <= ACK;
          end
        end
        ACK: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cbus_addr_o      = cbus_addr_q;
  assign cbus_cmd_array_o = cbus_cmd_q;
  assign mbus_ack_o       = mbus_ack_q;
  assign busy_o           = busy_q;
  assign grant_id_o       = grant_id_q;
  assign sched_timeout_o  = tmo_q;

endmodule

// File: tb/tb_mesi_isc_snoop_sched.sv
// Directed self-checking bench for mesi_isc_snoop_sched (timeout scenario only with the macro).
module tb_mesi_isc_snoop_sched;

  localparam logic [2:0] NOP = 3'd0, SWR = 3'd1, SRD = 3'd2, EWR = 3'd3, ERD = 3'd4;
  localparam logic [2:0] MWR = 3'd1, MRD = 3'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0][2:0]   mbus_cmd;
  logic [3:0][31:0]  mbus_addr;
  logic [3:0]        cbus_ack;
  logic [31:0]       cbus_addr;
  logic [3:0][2:0]   cbus_cmd;
  logic [3:0]        mbus_ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic              sched_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mesi_isc_snoop_sched #(
    .ADDR_WIDTH     (32),
    .MBUS_CMD_WIDTH (3),
    .CBUS_CMD_WIDTH (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mbus_cmd_array_i  (mbus_cmd),
    .mbus_addr_array_i (mbus_addr),
    .cbus_ack_i        (cbus_ack),
    .cbus_addr_o       (cbus_addr),
    .cbus_cmd_array_o  (cbus_cmd),
    .mbus_ack_o        (mbus_ack),
    .busy_o            (busy),
    .grant_id_o        (grant_id),
    .sched_timeout_o   (sched_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mbus_cmd[1] = MRD;
    mbus_addr[1] = 32'h0000_0011;
    tick();
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, NOP, NOP, NOP}) begin
      n_fail++; $display("FAIL reset_cmd: got %h want %h", cbus_cmd, {NOP, NOP, NOP, NOP});
    end
    n_checks++;
    if ({mbus_ack, busy, grant_id, sched_timeout} !== {4'b0000, 1'b0, 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL reset_outs: got ack=%b busy=%b gid=%0d tmo=%b want 0000 0 3 0",
                         mbus_ack, busy, grant_id, sched_timeout);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (grant_id !== 2'd1 || busy !== 1'b1 || cbus_cmd !== {SRD, SRD, NOP, SRD}) begin
      n_fail++; $display("FAIL reset_first_grant: got gid=%0d busy=%b cmd=%h want 1 1 %h",
                         grant_id, busy, cbus_cmd, {SRD, SRD, NOP, SRD});
    end
    cbus_ack = 4'b1101;
    tick();
    cbus_ack = 4'b0010;
    tick();
    n_checks++;
    if (mbus_ack !== 4'b0010) begin
      n_fail++; $display("FAIL reset_cpu1_ack: got %b want 0010", mbus_ack);
    end
    mbus_cmd[1] = NOP;
    cbus_ack = 4'b0000;
    tick();
  endtask

  task automatic test_single_rd();
    mbus_cmd[2] = MRD;
    mbus_addr[2] = 32'h0000_1234;
    tick();
    n_checks++;
    if (cbus_addr !== 32'h0000_1234 || cbus_cmd !== {SRD, NOP, SRD, SRD} || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_snoop: got addr=%h cmd=%h gid=%0d want 00001234 %h 2",
                         cbus_addr, cbus_cmd, grant_id, {SRD, NOP, SRD, SRD});
    end
    mbus_addr[2] = 32'h0000_FFFF;
    cbus_ack = 4'b1011;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, ERD, NOP, NOP} || cbus_addr !== 32'h0000_1234 || mbus_ack !== 4'b0) begin
      n_fail++; $display("FAIL single_enable: got cmd=%h addr=%h ack=%b want %h 00001234 0000",
                         cbus_cmd, cbus_addr, mbus_ack, {NOP, ERD, NOP, NOP});
    end
    cbus_ack = 4'b0100;
    tick();
    n_checks++;
    if (mbus_ack !== 4'b0100 || cbus_cmd !== {NOP, NOP, NOP, NOP}) begin
      n_fail++; $display("FAIL single_ack: got ack=%b cmd=%h want 0100 000", mbus_ack, cbus_cmd);
    end
    mbus_cmd[2] = NOP;
    cbus_ack = 4'b0000;
    tick();
    n_checks++;
    if (mbus_ack !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got ack=%b busy=%b want 0000 0", mbus_ack, busy);
    end
  endtask

  task automatic test_contention();
    logic [3:0]      oh;
    logic [3:0][2:0] exp_cmd;
    int              last_ack;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mbus_cmd[i]  = MWR;
      mbus_addr[i] = 32'h100 * (i + 1);
    end
    tick();
    rst = 1'b0;
    last_ack = 0;
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      tick();
      exp_cmd = {SWR, SWR, SWR, SWR};
      exp_cmd[i] = NOP;
      n_checks++;
      if (grant_id !== 2'(i) || cbus_cmd !== exp_cmd || cbus_addr !== 32'h100 * (i + 1)) begin
        n_fail++; $display("FAIL contention_snoop%0d: got gid=%0d cmd=%h addr=%h want %0d %h %h",
                           i, grant_id, cbus_cmd, cbus_addr, i, exp_cmd, 32'h100 * (i + 1));
      end
      cbus_ack = ~oh;
      tick();
      cbus_ack = oh;
      tick();
      n_checks++;
      if (mbus_ack !== oh) begin
        n_fail++; $display("FAIL contention_ack%0d: got %b want %b", i, mbus_ack, oh);
      end
      if (i > 0) begin
        n_checks++;
        if (cyc - last_ack !== 4) begin
          n_fail++; $display("FAIL contention_spacing%0d: got %0d want 4", i, cyc - last_ack);
        end
      end
      last_ack = cyc;
      mbus_cmd[i] = NOP;
      cbus_ack = 4'b0000;
      tick();
    end
  endtask

  task automatic test_staggered();
    mbus_cmd[0] = MWR;
    mbus_addr[0] = 32'h0000_ABCD;
    tick();
    n_checks++;
    if (cbus_cmd !== {SWR, SWR, SWR, NOP} || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL stagger_start: got cmd=%h gid=%0d want %h 0",
                         cbus_cmd, grant_id, {SWR, SWR, SWR, NOP});
    end
    tick();
    cbus_ack = 4'b1000;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, SWR, SWR, NOP}) begin
      n_fail++; $display("FAIL stagger_cpu3: got %h want %h", cbus_cmd, {NOP, SWR, SWR, NOP});
    end
    cbus_ack = 4'b0000;
    tick();
    cbus_ack = 4'b0010;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, SWR, NOP, NOP}) begin
      n_fail++; $display("FAIL stagger_cpu1: got %h want %h", cbus_cmd, {NOP, SWR, NOP, NOP});
    end
    cbus_ack = 4'b1001;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, SWR, NOP, NOP} || busy !== 1'b1) begin
      n_fail++; $display("FAIL stagger_ignored_acks: got cmd=%h busy=%b want %h 1",
                         cbus_cmd, busy, {NOP, SWR, NOP, NOP});
    end
    cbus_ack = 4'b0000;
    tick();
    cbus_ack = 4'b0100;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, NOP, NOP, EWR}) begin
      n_fail++; $display("FAIL stagger_enable: got %h want %h", cbus_cmd, {NOP, NOP, NOP, EWR});
    end
    cbus_ack = 4'b0001;
    tick();
    n_checks++;
    if (mbus_ack !== 4'b0001) begin
      n_fail++; $display("FAIL stagger_ack: got %b want 0001", mbus_ack);
    end
    mbus_cmd[0] = NOP;
    cbus_ack = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    mbus_cmd[3] = MRD;
    mbus_addr[3] = 32'h0000_3000;
    tick();
    cbus_ack = 4'b0111;
    tick();
    n_checks++;
    if (cbus_cmd !== {ERD, NOP, NOP, NOP} || grant_id !== 2'd3) begin
      n_fail++; $display("FAIL midrst_enable: got cmd=%h gid=%0d want %h 3",
                         cbus_cmd, grant_id, {ERD, NOP, NOP, NOP});
    end
    rst = 1'b1;
    cbus_ack = 4'b1000;
    tick();
    n_checks++;
    if (cbus_cmd !== {NOP, NOP, NOP, NOP} || mbus_ack !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: got cmd=%h ack=%b busy=%b want 000 0000 0",
                         cbus_cmd, mbus_ack, busy);
    end
    rst = 1'b0;
    cbus_ack = 4'b0000;
    mbus_cmd[0] = MRD;
    mbus_addr[0] = 32'h0000_0040;
    tick();
    n_checks++;
    if (grant_id !== 2'd0 || mbus_ack !== 4'b0) begin
      n_fail++; $display("FAIL midrst_cpu0_first: got gid=%0d ack=%b want 0 0000", grant_id, mbus_ack);
    end
    cbus_ack = 4'b1110;
    tick();
    cbus_ack = 4'b0001;
    tick();
    mbus_cmd[0] = NOP;
    cbus_ack = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (grant_id !== 2'd3 || cbus_cmd !== {NOP, SRD, SRD, SRD}) begin
      n_fail++; $display("FAIL midrst_rearb: got gid=%0d cmd=%h want 3 %h",
                         grant_id, cbus_cmd, {NOP, SRD, SRD, SRD});
    end
    cbus_ack = 4'b0111;
    tick();
    cbus_ack = 4'b1000;
    tick();
    n_checks++;
    if (mbus_ack !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_cpu3_ack: got %b want 1000", mbus_ack);
    end
    mbus_cmd[3] = NOP;
    cbus_ack = 4'b0000;
    tick();
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 4; i++) mbus_cmd[i] = 3'(3 + i);
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || cbus_cmd !== {NOP, NOP, NOP, NOP}) begin
      n_fail++; $display("FAIL ignore_bad_cmd: got busy=%b cmd=%h want 0 000", busy, cbus_cmd);
    end
    for (int i = 0; i < 4; i++) mbus_cmd[i] = NOP;
  endtask

`ifdef MESI_ISC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mbus_cmd[0] = MWR;
    mbus_cmd[1] = MRD;
    mbus_cmd[2] = MRD;
    tick();
    cbus_ack = 4'b1100;
    tick();
    cbus_ack = 4'b0000;
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (sched_timeout !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early%0d: got 1 want 0", k);
      end
    end
    tick();
    n_checks++;
    if (sched_timeout !== 1'b1 || mbus_ack !== 4'b0 || cbus_cmd !== {NOP, NOP, NOP, NOP}) begin
      n_fail++; $display("FAIL timeout_pulse: got tmo=%b ack=%b cmd=%h want 1 0000 000",
                         sched_timeout, mbus_ack, cbus_cmd);
    end
    tick();
    n_checks++;
    if (sched_timeout !== 1'b0 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL timeout_next: got tmo=%b gid=%0d want 0 1", sched_timeout, grant_id);
    end
    for (int i = 0; i < 4; i++) mbus_cmd[i] = NOP;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    mbus_cmd = '0;
    mbus_addr = '0;
    cbus_ack = 4'b0000;
    test_reset();
    test_single_rd();
    test_contention();
    test_staggered();
    test_mid_reset();
    test_ignore();
`ifdef MESI_ISC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
